mem_port_arbiter: RTL and testbench

Two-requester arbiter sharing one single-port synchronous memory between the core's instruction-fetch port and data port. It sits between the `riscv` core and a unified instruction/data memory. The arbiter grants at most one access per cycle, routes the one-cycle-latency read data back to the owner, and guards against starvation. The core stalls on a port whenever that port's request is not granted.

---
 rtl/mem_port_arbiter_if.sv | 59 +++++
 rtl/mem_port_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
//
// Bundles the two requester ports (instruction fetch, data) and the shared
// single-port memory port of mem_port_arbiter.
//
//   i_*  : instruction read port   (req/addr in, gnt/rvalid/rdata out)
//   d_*  : data read/write port    (req/we/addr/wdata in, gnt/rvalid/rdata out)
//   m_*  : memory side            (ce/we/addr/wdata out, rdata in)
//
// Modports:
//   slave  - the arbiter's view
//   master - the environment's view (core ports + memory)
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Instruction port
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [DATA_W-1:0] i_rdata;

  // Data port
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  // Memory port
  logic              m_ce;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;

  modport slave (
    input  i_req, i_addr,
    output i_gnt, i_rvalid, i_rdata,
    input  d_req, d_we, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    output m_ce, m_we, m_addr, m_wdata,
    input  m_rdata
  );

  modport master (
    output i_req, i_addr,
    input  i_gnt, i_rvalid, i_rdata,
    output d_req, d_we, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  m_ce, m_we, m_addr, m_wdata,
    output m_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port synchronous memory (1-cycle read latency) between the
// core's instruction-fetch port and data port. At most one access is granted
// per cycle, the grant is combinational (0-cycle latency), and the read data
// returning one cycle later is steered back to the port that issued the read.
//
// Ports:
//   clk           clock, rising edge
//   rst           asynchronous, active-low reset
//   bus           mem_port_arbiter_if.slave (i_*, d_*, m_* signals)
//   conflict_cnt  saturating count of cycles with both requests high
//
// Conflict policy:
//   default                 data wins; after MAX_BURST consecutive data grants
//                           with the instruction port waiting, the instruction
//                           port wins the next conflict.
//   `define ARB_ROUND_ROBIN_EN
//                           conflicts alternate; the first one after reset
//                           goes to the instruction port. MAX_BURST unused.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4    // 1..15
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_port_arbiter_if.slave    bus,
  output logic [15:0]          conflict_cnt
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INST = 2'd1,
    OWN_DATA = 2'd2
  } own_e;

  own_e       resp_own;   // which port the read data arriving this cycle belongs to
  logic       conflict;
  logic       inst_wins;  // winner of a conflict in the current cycle
  logic [3:0] burst_cnt;

  assign conflict = bus.i_req & bus.d_req;

`ifdef ARB_ROUND_ROBIN_EN
  // Remembers the winner of the most recent conflict; the other port wins next.
  logic last_win_inst;

  assign inst_wins = ~last_win_inst;
  assign burst_cnt = 4'd0;
`else
  localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);

  assign inst_wins = (burst_cnt == BURST_LIMIT);
`endif

  // ---------------------------------------------------------------------------
  // Grants. Gated by rst so nothing reaches the memory while reset is held,
  // even though the requesters may still be asserting req.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through it leaves a value unassigned (which would infer a latch).
    bus.i_gnt = 1'b0;
    bus.d_gnt = 1'b0;
    if (rst) begin
      if (conflict) begin
        bus.i_gnt = inst_wins;
        bus.d_gnt = ~inst_wins;
      end else begin
        bus.i_gnt = bus.i_req;
        bus.d_gnt = bus.d_req;
      end
    end
  end

  // Memory drive: muxed from the granted port, all zero when idle.
  always_comb begin
    bus.m_ce    = bus.i_gnt | bus.d_gnt;
    bus.m_we    = bus.d_gnt & bus.d_we;
    bus.m_addr  = '0;
    bus.m_wdata = '0;
    if (bus.d_gnt) begin
      bus.m_addr  = bus.d_addr;
      bus.m_wdata = bus.d_wdata;
    end else if (bus.i_gnt) begin
      bus.m_addr  = bus.i_addr;
    end
  end

  // Response routing: only the owner sees m_rdata, the other port reads 0.
  assign bus.i_rvalid = (resp_own == OWN_INST);
  assign bus.d_rvalid = (resp_own == OWN_DATA);
  assign bus.i_rdata  = bus.i_rvalid ? bus.m_rdata : '0;
  assign bus.d_rdata  = bus.d_rvalid ? bus.m_rdata : '0;

  // ---------------------------------------------------------------------------
  // Response owner and conflict statistics.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_own     <= OWN_NONE;
      conflict_cnt <= 16'd0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (bus.i_gnt)                   resp_own <= OWN_INST;
      else if (bus.d_gnt && !bus.d_we) resp_own <= OWN_DATA;
      else                             resp_own <= OWN_NONE;  // writes return nothing

      if (conflict && (conflict_cnt != 16'hFFFF))
        conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_win_inst <= 1'b0;            // data counts as the last winner
    end else if (conflict) begin
      last_win_inst <= bus.i_gnt;
    end
  end
`else
  // Counts data grants made while the instruction port is kept waiting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      burst_cnt <= 4'd0;
    end else if (bus.i_gnt || !bus.i_req) begin
      burst_cnt <= 4'd0;
    end else if (bus.d_gnt) begin
      burst_cnt <= burst_cnt + 4'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Bench for mem_port_arbiter: reset state, a directed vector table, a
// sustained-conflict sequence, reset with a read in flight, randomized traffic
// against a transaction-level model, and conflict_cnt saturation.
// Honours `ARB_ROUND_ROBIN_EN for the expected conflict policy.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int MAX_BURST = 4;

  typedef enum {P_NONE, P_INST, P_DATA} port_e;

  typedef struct packed {
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
  } in_t;

  typedef struct packed {
    logic        i_gnt;
    logic        d_gnt;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        d_rvalid;
    logic [31:0] d_rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] conflict_cnt;
  int          n_checks = 0;
  int          n_pass   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .conflict_cnt (conflict_cnt)
  );

  // ---------------------------------------------------------------------------
  // Memory: 256 words selected by addr[9:2], one-cycle read latency. When no
  // read was issued m_rdata carries junk so stray routing shows up.
  // ---------------------------------------------------------------------------
  logic [31:0] mem [0:255];

  always @(posedge clk) begin
    if (bus.m_ce && bus.m_we) mem[bus.m_addr[9:2]] <= bus.m_wdata;
    bus.m_rdata <= (bus.m_ce && !bus.m_we) ? mem[bus.m_addr[9:2]] : $urandom;
  end

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem[a[9:2]];
  endfunction

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
  endtask

  task automatic check_outputs(input string tag, input exp_t e);
    check({tag, " i_gnt"},    32'(bus.i_gnt),    32'(e.i_gnt));
    check({tag, " d_gnt"},    32'(bus.d_gnt),    32'(e.d_gnt));
    check({tag, " m_ce"},     32'(bus.m_ce),     32'(e.i_gnt | e.d_gnt));
    check({tag, " m_we"},     32'(bus.m_we),     32'(e.m_we));
    check({tag, " m_addr"},   bus.m_addr,        e.m_addr);
    check({tag, " m_wdata"},  bus.m_wdata,       e.m_wdata);
    check({tag, " i_rvalid"}, 32'(bus.i_rvalid), 32'(e.i_rvalid));
    check({tag, " i_rdata"},  bus.i_rdata,       e.i_rdata);
    check({tag, " d_rvalid"}, 32'(bus.d_rvalid), 32'(e.d_rvalid));
    check({tag, " d_rdata"},  bus.d_rdata,       e.d_rdata);
  endtask

  // Inputs are applied 1 unit after a rising edge; outputs compared 1 unit later.
  task automatic drive(input in_t v);
    bus.i_req   = v.i_req;
    bus.i_addr  = v.i_addr;
    bus.d_req   = v.d_req;
    bus.d_we    = v.d_we;
    bus.d_addr  = v.d_addr;
    bus.d_wdata = v.d_wdata;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive('0);
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Randomized traffic against a transaction-level model. Requesters hold req
  // and payload until granted, as the core does.
  // ---------------------------------------------------------------------------
  task automatic run_random(input int n_cycles);
    port_e       pend        = P_NONE;  // owner of the response due this cycle
    logic [31:0] pend_data   = '0;
    int          passed_over = 0;       // data wins while instruction kept waiting
    port_e       last_conf   = P_DATA;  // winner of the most recent conflict
    int          conflicts   = 0;
    logic        i_wait      = 1'b0;
    logic        d_wait      = 1'b0;
    in_t         cur         = '0;
    port_e       win;
    exp_t        e;

    for (int c = 0; c < n_cycles; c++) begin
      if (!i_wait) begin
        cur.i_req  = ($urandom_range(0, 3) != 0);
        cur.i_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!d_wait) begin
        cur.d_req   = ($urandom_range(0, 4) < 3);
        cur.d_we    = 1'($urandom_range(0, 1));
        cur.d_addr  = $urandom & 32'hFFFF_FFFC;
        cur.d_wdata = $urandom;
      end

      if (cur.i_req && cur.d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
        win = (last_conf == P_INST) ? P_DATA : P_INST;
`else
        win = (passed_over >= MAX_BURST) ? P_INST : P_DATA;
`endif
      end else if (cur.i_req) win = P_INST;
      else if (cur.d_req)     win = P_DATA;
      else                    win = P_NONE;

      e          = '0;
      e.i_gnt    = (win == P_INST);
      e.d_gnt    = (win == P_DATA);
      e.m_we     = (win == P_DATA) && cur.d_we;
      e.m_addr   = (win == P_INST) ? cur.i_addr : (win == P_DATA) ? cur.d_addr : 32'h0;
      e.m_wdata  = (win == P_DATA) ? cur.d_wdata : 32'h0;
      e.i_rvalid = (pend == P_INST);
      e.i_rdata  = (pend == P_INST) ? pend_data : 32'h0;
      e.d_rvalid = (pend == P_DATA);
      e.d_rdata  = (pend == P_DATA) ? pend_data : 32'h0;

      drive(cur);
      check_outputs($sformatf("rnd%0d", c), e);
      check($sformatf("rnd%0d conflict_cnt", c), 32'(conflict_cnt),
            (conflicts > 65535) ? 32'hFFFF : 32'(conflicts));

      // Advance the model to the next cycle.
      if (win == P_INST) begin
        pend      = P_INST;
        pend_data = mem_rd(cur.i_addr);
      end else if (win == P_DATA && !cur.d_we) begin
        pend      = P_DATA;
        pend_data = mem_rd(cur.d_addr);
      end else begin
        pend      = P_NONE;
      end
      if (cur.i_req && cur.d_req) begin
        conflicts++;
        last_conf = win;
      end
      if (!cur.i_req || win == P_INST) passed_over = 0;
      else                             passed_over++;
      i_wait = cur.i_req && (win != P_INST);
      d_wait = cur.d_req && (win != P_DATA);
      tick();
    end
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  in_t   vin [8];
  exp_t  vex [8];
  string seq;
  port_e prev;
  exp_t  e;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] <= $urandom;
    mem[8'h40] <= 32'h0000_0013;   // 0x100
    mem[8'h41] <= 32'h0050_0093;   // 0x104
    mem[8'h82] <= 32'h0BAD_F00D;   // 0x208
    mem[8'hD0] <= 32'h1111_0340;   // 0x340
    mem[8'hE0] <= 32'h2222_0380;   // 0x380

    //          i_req i_addr      d_req d_we d_addr      d_wdata
    vin[0] = '{1'b1, 32'h100,    1'b0, 1'b0, 32'h0,     32'h0};
    vin[1] = '{1'b0, 32'h0,      1'b1, 1'b1, 32'h200,   32'hDEADBEEF};
    vin[2] = '{1'b0, 32'h0,      1'b0, 1'b0, 32'h0,     32'h0};
    vin[3] = '{1'b0, 32'h0,      1'b1, 1'b0, 32'h200,   32'h0};
    vin[4] = '{1'b1, 32'h104,    1'b0, 1'b0, 32'h0,     32'h0};
    vin[5] = '{1'b0, 32'h0,      1'b0, 1'b0, 32'h0,     32'h0};
    vin[6] = '{1'b0, 32'h0,      1'b1, 1'b0, 32'h208,   32'h0};
    vin[7] = '{1'b0, 32'h0,      1'b0, 1'b0, 32'h0,     32'h0};
    //          i_gnt d_gnt m_we  m_addr    m_wdata        i_rv  i_rdata        d_rv  d_rdata
    vex[0] = '{1'b1, 1'b0, 1'b0, 32'h100, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0};
    vex[1] = '{1'b0, 1'b1, 1'b1, 32'h200, 32'hDEADBEEF, 1'b1, 32'h13,       1'b0, 32'h0};
    vex[2] = '{1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 32'h0,        1'b0, 32'h0};
    vex[3] = '{1'b0, 1'b1, 1'b0, 32'h200, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0};
    vex[4] = '{1'b1, 1'b0, 1'b0, 32'h104, 32'h0,        1'b0, 32'h0,        1'b1, 32'hDEADBEEF};
    vex[5] = '{1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 32'h0050_0093, 1'b0, 32'h0};
    vex[6] = '{1'b0, 1'b1, 1'b0, 32'h208, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0};
    vex[7] = '{1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 32'h0,        1'b1, 32'h0BAD_F00D};

    // Reset: outputs all zero even with both requests asserted.
    #1 rst = 1'b0;
    drive('{1'b1, 32'h340, 1'b1, 1'b0, 32'h380, 32'h0});
    check_outputs("reset", '0);
    check("reset conflict_cnt", 32'(conflict_cnt), 32'h0);
    tick();
    tick();
    check_outputs("reset held", '0);
    check("reset held conflict_cnt", 32'(conflict_cnt), 32'h0);

    // Release; the very first cycle with rst=1 already grants.
    rst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      drive(vin[k]);
      check_outputs($sformatf("vec%0d", k), vex[k]);
      tick();
    end
    drive('0);
    check("vec conflict_cnt", 32'(conflict_cnt), 32'h0);

    // Sustained conflict for 10 cycles.
`ifdef ARB_ROUND_ROBIN_EN
    seq = "IDIDIDIDID";
`else
    seq = "DDDDIDDDDI";
`endif
    prev = P_NONE;
    for (int k = 0; k < 10; k++) begin
      drive('{1'b1, 32'h340, 1'b1, 1'b0, 32'h380, 32'h0});
      e          = '0;
      e.i_gnt    = (seq[k] == "I");
      e.d_gnt    = (seq[k] == "D");
      e.m_addr   = e.i_gnt ? 32'h340 : 32'h380;
      e.i_rvalid = (prev == P_INST);
      e.i_rdata  = (prev == P_INST) ? 32'h1111_0340 : 32'h0;
      e.d_rvalid = (prev == P_DATA);
      e.d_rdata  = (prev == P_DATA) ? 32'h2222_0380 : 32'h0;
      check_outputs($sformatf("conf%0d", k), e);
      prev = e.i_gnt ? P_INST : P_DATA;
      tick();
    end
    drive('0);
    e          = '0;
    e.i_rvalid = (prev == P_INST);
    e.i_rdata  = (prev == P_INST) ? 32'h1111_0340 : 32'h0;
    e.d_rvalid = (prev == P_DATA);
    e.d_rdata  = (prev == P_DATA) ? 32'h2222_0380 : 32'h0;
    check_outputs("conf tail", e);
    check("conf conflict_cnt", 32'(conflict_cnt), 32'd10);
    tick();

    // Reset while a data read is in flight.
    drive('{1'b0, 32'h0, 1'b1, 1'b0, 32'h380, 32'h0});
    e        = '0;
    e.d_gnt  = 1'b1;
    e.m_addr = 32'h380;
    check_outputs("midrd grant", e);
    bus.i_req = 1'b1;
    rst       = 1'b0;
    #1;
    check_outputs("midrd async", '0);
    check("midrd async conflict_cnt", 32'(conflict_cnt), 32'h0);
    tick();
    drive('0);
    tick();
    rst = 1'b1;
    #1;
    check_outputs("midrd release", '0);
    check("midrd release conflict_cnt", 32'(conflict_cnt), 32'h0);
    tick();
    drive('0);
    check_outputs("midrd after", '0);
    tick();

    // Randomized traffic from a clean reset.
    do_reset();
    run_random(3000);

    // conflict_cnt saturation.
    do_reset();
    drive('{1'b1, 32'h340, 1'b1, 1'b0, 32'h380, 32'h0});
    repeat (65534) @(posedge clk);
    #1;
    check("sat 65534", 32'(conflict_cnt), 32'hFFFE);
    @(posedge clk);
    #1;
    check("sat 65535", 32'(conflict_cnt), 32'hFFFF);
    repeat (4465) @(posedge clk);
    #1;
    check("sat 70000", 32'(conflict_cnt), 32'hFFFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
